// File: rtl/prf_multiport.sv
// ---------------------------------------------------------------------------
// prf_multiport
//   Parametrised physical register file with a per-entry ready scoreboard.
//   Rename/dispatch clears ready bits through the allocate ports and polls
//   them through the read ports. Writeback fills entries through the write
//   ports, which also set the ready bit. Flush marks every entry ready.
//   The read path bypasses same-cycle writes, and REG_READ selects a
//   combinational or a one-cycle registered read.
//
// Ports
//   clk         clock
//   reset       asynchronous, active-high reset
//   wen         [NWR]          write enables
//   wtag        [NWR*TW]       write tags, port p at bits p*TW +: TW
//   wdata       [NWR*XLEN]     write data, port p at bits p*XLEN +: XLEN
//   alloc_en    [NALLOC]       allocate enables (clear ready)
//   alloc_tag   [NALLOC*TW]    allocated tags
//   flush       set every ready bit (takes priority over allocs)
//   rtag        [NRD*TW]       read tags
//   rdata       [NRD*XLEN]     read data
//   rready      [NRD]          ready bit of each read tag
//   err_collide sticky flag: two enabled write ports hit the same tag
// ---------------------------------------------------------------------------
module prf_multiport #(
    parameter int              XLEN      = 32,
    parameter int              PREGS     = 64,
    parameter int              NWR       = 2,
    parameter int              NRD       = 6,
    parameter int              NALLOC    = 2,
    parameter logic [XLEN-1:0] RESET_VAL = '0,
    parameter bit              ZERO_PREG = 1'b1,
    parameter bit              REG_READ  = 1'b0,
    localparam int             TW        = $clog2(PREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NWR-1:0]         wen,
    input  logic [NWR*TW-1:0]      wtag,
    input  logic [NWR*XLEN-1:0]    wdata,
    input  logic [NALLOC-1:0]      alloc_en,
    input  logic [NALLOC*TW-1:0]   alloc_tag,
    input  logic                   flush,
    input  logic [NRD*TW-1:0]      rtag,
    output logic [NRD*XLEN-1:0]    rdata,
    output logic [NRD-1:0]         rready,
    output logic                   err_collide
);

    // Storage
    logic [XLEN-1:0] mem [PREGS];
    logic [PREGS-1:0] ready;

    // Per-port views of the flat buses
    logic [TW-1:0]   wtag_a  [NWR];
    logic [XLEN-1:0] wdata_a [NWR];
    logic [TW-1:0]   atag_a  [NALLOC];
    logic [TW-1:0]   rtag_a  [NRD];

    for (genvar p = 0; p < NWR; p++) begin : g_wr_unpack
        assign wtag_a[p]  = wtag[p*TW +: TW];
        assign wdata_a[p] = wdata[p*XLEN +: XLEN];
    end
    for (genvar a = 0; a < NALLOC; a++) begin : g_al_unpack
        assign atag_a[a] = alloc_tag[a*TW +: TW];
    end
    for (genvar r = 0; r < NRD; r++) begin : g_rd_unpack
        assign rtag_a[r] = rtag[r*TW +: TW];
    end

    // Tag 0 is the hard-wired zero register when ZERO_PREG is set.
    function automatic logic is_zero(input logic [TW-1:0] t);
        return ZERO_PREG && (t == '0);
    endfunction

    // A write port takes effect only if it is enabled and not aimed at the
    // zero register; this also keeps tag-0 collisions out of err_collide.
    logic [NWR-1:0] wr_ok;
    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            wr_ok[p] = wen[p] && !is_zero(wtag_a[p]);
        end
    end

    logic collide;
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (wr_ok[i] && wr_ok[j] && (wtag_a[i] == wtag_a[j])) begin
                    collide = 1'b1;
                end
            end
        end
    end

    // Data array
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data array is reset on purpose: every entry must read
            // RESET_VAL straight after reset, so it cannot be a reset-less RAM.
            for (int e = 0; e < PREGS; e++) begin
                mem[e] <= RESET_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments to one entry resolve to the last
            // one executed, so walking ports high-to-low lets the lowest win.
            for (int p = NWR - 1; p >= 0; p--) begin
                if (wr_ok[p]) begin
                    mem[wtag_a[p]] <= wdata_a[p];
                end
            end
        end
    end

    // Ready scoreboard: writes set, allocs clear (allocs are applied last so
    // they win on the same tag), flush sets everything and drops the allocs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= '1;
        end else if (flush) begin
            ready <= '1;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_ok[p]) begin
                    ready[wtag_a[p]] <= 1'b1;
                end
            end
            for (int a = 0; a < NALLOC; a++) begin
                if (alloc_en[a] && !is_zero(atag_a[a])) begin
                    ready[atag_a[a]] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_collide <= 1'b0;
        end else if (collide) begin
            err_collide <= 1'b1;
        end
    end

    // Read lookup: stored value, overridden by the lowest-index matching
    // write (bypass), overridden by the zero register. Same-cycle allocs are
    // deliberately not bypassed into the ready result.
    logic [XLEN-1:0] rd_data [NRD];
    logic [NRD-1:0]  rd_rdy;

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            // NOTE: each result gets its default before the priority overrides,
            // so every path assigns it and no latch is inferred.
            rd_data[r] = mem[rtag_a[r]];
            rd_rdy[r]  = ready[rtag_a[r]];
            for (int p = NWR - 1; p >= 0; p--) begin
                if (wen[p] && (wtag_a[p] == rtag_a[r])) begin
                    rd_data[r] = wdata_a[p];
                    rd_rdy[r]  = 1'b1;
                end
            end
            if (is_zero(rtag_a[r])) begin
                rd_data[r] = '0;
                rd_rdy[r]  = 1'b1;
            end
        end
    end

    if (REG_READ) begin : g_reg_read
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata  <= '0;
                rready <= '0;
            end else begin
                for (int r = 0; r < NRD; r++) begin
                    rdata[r*XLEN +: XLEN] <= rd_data[r];
                end
                rready <= rd_rdy;
            end
        end
    end else begin : g_comb_read
        for (genvar r = 0; r < NRD; r++) begin : g_port
            assign rdata[r*XLEN +: XLEN] = rd_data[r];
        end
        assign rready = rd_rdy;
    end

endmodule

// File: tb/tb_prf_multiport.sv
// ---------------------------------------------------------------------------
// tb_prf_multiport
//   Drives two register files from the same inputs:
//     dut0: combinational read, zero register on, RESET_VAL = 4
//     dut1: registered read, zero register off, RESET_VAL = 4
//   A behavioural model (plain arrays, first-match lookup) predicts both.
//   A vector table covers the directed scenarios, followed by hand-written
//   registered-read/reset sequences and a randomized run.
// ---------------------------------------------------------------------------
module tb_prf_multiport;

    localparam int XLEN   = 32;
    localparam int PREGS  = 64;
    localparam int NWR    = 2;
    localparam int NRD    = 6;
    localparam int NALLOC = 2;
    localparam int TW     = $clog2(PREGS);
    localparam logic [XLEN-1:0] RV = 32'd4;

    logic clk = 1'b0;
    logic reset;
    logic [NWR-1:0]                wen;
    logic [NWR-1:0][TW-1:0]        wtag;
    logic [NWR-1:0][XLEN-1:0]      wdata;
    logic [NALLOC-1:0]             alloc_en;
    logic [NALLOC-1:0][TW-1:0]     alloc_tag;
    logic                          flush;
    logic [NRD-1:0][TW-1:0]        rtag;
    logic [NRD-1:0][XLEN-1:0]      rdata0, rdata1;
    logic [NRD-1:0]                rready0, rready1;
    logic                          err0, err1;

    always #5 clk = ~clk;

    prf_multiport #(
        .XLEN(XLEN), .PREGS(PREGS), .NWR(NWR), .NRD(NRD), .NALLOC(NALLOC),
        .RESET_VAL(RV), .ZERO_PREG(1'b1), .REG_READ(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .wen(wen), .wtag(wtag), .wdata(wdata),
        .alloc_en(alloc_en), .alloc_tag(alloc_tag), .flush(flush),
        .rtag(rtag), .rdata(rdata0), .rready(rready0), .err_collide(err0)
    );

    prf_multiport #(
        .XLEN(XLEN), .PREGS(PREGS), .NWR(NWR), .NRD(NRD), .NALLOC(NALLOC),
        .RESET_VAL(RV), .ZERO_PREG(1'b0), .REG_READ(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .wen(wen), .wtag(wtag), .wdata(wdata),
        .alloc_en(alloc_en), .alloc_tag(alloc_tag), .flush(flush),
        .rtag(rtag), .rdata(rdata1), .rready(rready1), .err_collide(err1)
    );

    // ---------------- reference model ----------------
    // Index 0 models dut0 (zero register), index 1 models dut1.
    logic [XLEN-1:0] m_data [2][PREGS];
    bit              m_rdy  [2][PREGS];
    bit              m_err  [2];
    logic [XLEN-1:0] q_data [NRD];   // dut1 output expected this cycle
    bit              q_rdy  [NRD];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit zp(input int c, input logic [TW-1:0] t);
        return (c == 0) && (t == '0);
    endfunction

    function automatic void ref_read(input int c, input logic [TW-1:0] t,
                                     output logic [XLEN-1:0] d, output bit rdy);
        bit hit;
        hit = 1'b0;
        d   = m_data[c][t];
        rdy = m_rdy[c][t];
        for (int p = 0; p < NWR; p++) begin
            if (!hit && wen[p] && wtag[p] == t) begin
                d   = wdata[p];
                rdy = 1'b1;
                hit = 1'b1;
            end
        end
        if (zp(c, t)) begin
            d   = '0;
            rdy = 1'b1;
        end
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int t = 0; t < PREGS; t++) begin
                m_data[c][t] = RV;
                m_rdy[c][t]  = 1'b1;
            end
            m_err[c] = 1'b0;
        end
        for (int r = 0; r < NRD; r++) begin
            q_data[r] = '0;
            q_rdy[r]  = 1'b0;
        end
    endtask

    task automatic model_commit();
        bit taken [PREGS];
        for (int c = 0; c < 2; c++) begin
            for (int t = 0; t < PREGS; t++) taken[t] = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (wen[p] && !zp(c, wtag[p])) begin
                    if (taken[wtag[p]]) begin
                        m_err[c] = 1'b1;
                    end else begin
                        m_data[c][wtag[p]] = wdata[p];
                        taken[wtag[p]] = 1'b1;
                    end
                end
            end
            if (flush) begin
                for (int t = 0; t < PREGS; t++) m_rdy[c][t] = 1'b1;
            end else begin
                for (int t = 0; t < PREGS; t++) if (taken[t]) m_rdy[c][t] = 1'b1;
                for (int a = 0; a < NALLOC; a++) begin
                    if (alloc_en[a] && !zp(c, alloc_tag[a])) m_rdy[c][alloc_tag[a]] = 1'b0;
                end
            end
        end
    endtask

    // Compare both DUTs with the model at the falling edge.
    task automatic sample_checks();
        logic [XLEN-1:0] d;
        bit r;
        @(negedge clk);
        for (int p = 0; p < NRD; p++) begin
            ref_read(0, rtag[p], d, r);
            check($sformatf("comb_rdata[%0d] tag %0d", p, rtag[p]), 64'(rdata0[p]), 64'(d));
            check($sformatf("comb_rready[%0d] tag %0d", p, rtag[p]), 64'(rready0[p]), 64'(r));
            check($sformatf("reg_rdata[%0d]", p), 64'(rdata1[p]), 64'(q_data[p]));
            check($sformatf("reg_rready[%0d]", p), 64'(rready1[p]), 64'(q_rdy[p]));
        end
        check("err_collide dut0", 64'(err0), 64'(m_err[0]));
        check("err_collide dut1", 64'(err1), 64'(m_err[1]));
    endtask

    // Cross the rising edge and update the model with the same inputs.
    task automatic advance();
        logic [XLEN-1:0] nd [NRD];
        bit nr [NRD];
        for (int p = 0; p < NRD; p++) ref_read(1, rtag[p], nd[p], nr[p]);
        @(posedge clk);
        model_commit();
        for (int p = 0; p < NRD; p++) begin
            q_data[p] = nd[p];
            q_rdy[p]  = nr[p];
        end
        #1;
    endtask

    task automatic idle_inputs();
        wen = '0; wtag = '0; wdata = '0;
        alloc_en = '0; alloc_tag = '0; flush = 1'b0;
    endtask

    task automatic random_inputs();
        wen      = NWR'($urandom);
        alloc_en = NALLOC'($urandom);
        flush    = ($urandom_range(0, 15) == 0);
        for (int p = 0; p < NWR; p++) begin
            wtag[p]  = TW'($urandom_range(0, 15));
            wdata[p] = $urandom;
        end
        for (int a = 0; a < NALLOC; a++) alloc_tag[a] = TW'($urandom_range(0, 15));
        for (int r = 0; r < NRD; r++) begin
            rtag[r] = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, PREGS - 1))
                                                  : TW'($urandom_range(0, 15));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        sample_checks();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]      wen;
        logic [TW-1:0]   wt0, wt1;
        logic [XLEN-1:0] wd0, wd1;
        logic [1:0]      ae;
        logic [TW-1:0]   at0, at1;
        logic            fl;
        logic [TW-1:0]   rt0;
        logic [XLEN-1:0] exp_d;
        logic            exp_r;
        logic            exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] w, input int t0, input logic [XLEN-1:0] d0,
                                input int t1, input logic [XLEN-1:0] d1,
                                input logic [1:0] ae, input int a0, input int a1,
                                input logic fl, input int rt0,
                                input logic [XLEN-1:0] ed, input logic er, input logic ee);
        vec_t v;
        v.wen = w;  v.wt0 = TW'(t0); v.wd0 = d0; v.wt1 = TW'(t1); v.wd1 = d1;
        v.ae = ae;  v.at0 = TW'(a0); v.at1 = TW'(a1); v.fl = fl; v.rt0 = TW'(rt0);
        v.exp_d = ed; v.exp_r = er; v.exp_err = ee;
        return v;
    endfunction

    vec_t vecs [$];

    initial begin
        // Each row is one cycle; expectations are for dut0 port 0 and
        // err_collide as seen during that cycle.
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0,  1, 32'h4,    1, 0));
        vecs.push_back(mk(2'b11,  0, 'hFFFF,  0, 'hEEEE,  2'b01, 0, 0, 0,  0, 32'h0,    1, 0));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0,  0, 32'h0,    1, 0));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b01, 9, 0, 0,  9, 32'h4,    1, 0));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0,  9, 32'h4,    0, 0));
        vecs.push_back(mk(2'b10,  0, 0,       9, 'hABCD,  2'b00, 0, 0, 0,  9, 32'hABCD, 1, 0));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0,  9, 32'hABCD, 1, 0));
        vecs.push_back(mk(2'b11, 12, 'h11,   12, 'h22,    2'b00, 0, 0, 0, 12, 32'h11,   1, 0));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0, 12, 32'h11,   1, 1));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b11, 5, 6, 0,  5, 32'h4,    1, 1));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b01, 7, 0, 1,  5, 32'h4,    0, 1));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0,  5, 32'h4,    1, 1));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0,  6, 32'h4,    1, 1));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0,  7, 32'h4,    1, 1));
        vecs.push_back(mk(2'b01,  8, 'h8888,  0, 0,       2'b01, 8, 0, 0,  8, 32'h8888, 1, 1));
        vecs.push_back(mk(2'b00,  0, 0,       0, 0,       2'b00, 0, 0, 0,  8, 32'h8888, 0, 1));
    end

    // ---------------- main sequence ----------------
    initial begin
        rtag = '0;
        #1;
        do_reset();

        // Reset contents: tags 1..5 on ports 0..4.
        for (int p = 0; p < NRD; p++) rtag[p] = TW'(p + 1);
        sample_checks();
        for (int p = 0; p < 5; p++) begin
            check($sformatf("reset rdata[%0d]", p), 64'(rdata0[p]), 64'(RV));
            check($sformatf("reset rready[%0d]", p), 64'(rready0[p]), 64'd1);
        end
        check("reset err_collide", 64'(err0), 64'd0);
        advance();

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            wen = vecs[i].wen;
            wtag[0] = vecs[i].wt0;  wdata[0] = vecs[i].wd0;
            wtag[1] = vecs[i].wt1;  wdata[1] = vecs[i].wd1;
            alloc_en = vecs[i].ae;
            alloc_tag[0] = vecs[i].at0;  alloc_tag[1] = vecs[i].at1;
            flush = vecs[i].fl;
            rtag[0] = vecs[i].rt0;
            for (int r = 1; r < NRD; r++) rtag[r] = TW'($urandom_range(0, 15));
            sample_checks();
            check($sformatf("vec%0d rdata", i), 64'(rdata0[0]), 64'(vecs[i].exp_d));
            check($sformatf("vec%0d rready", i), 64'(rready0[0]), 64'(vecs[i].exp_r));
            check($sformatf("vec%0d err_collide", i), 64'(err0), 64'(vecs[i].exp_err));
            advance();
        end

        // Registered read: result of cycle N appears in cycle N+1.
        do_reset();
        rtag = '0;
        rtag[0] = TW'(3);
        sample_checks();
        check("regread before capture rdata", 64'(rdata1[0]), 64'd0);
        check("regread before capture rready", 64'(rready1[0]), 64'd0);
        advance();
        wen[0] = 1'b1; wtag[0] = TW'(3); wdata[0] = 32'h55;
        sample_checks();
        check("regread same cycle rdata", 64'(rdata1[0]), 64'(RV));
        check("regread same cycle rready", 64'(rready1[0]), 64'd1);
        advance();
        idle_inputs();
        sample_checks();
        check("regread next cycle rdata", 64'(rdata1[0]), 64'h55);
        check("regread next cycle rready", 64'(rready1[0]), 64'd1);
        advance();

        // Reset asserted in the middle of a burst, between clock edges.
        for (int k = 0; k < 4; k++) begin
            random_inputs();
            sample_checks();
            advance();
        end
        random_inputs();
        #2;
        reset = 1'b1;
        #1;
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("async reset rdata[%0d]", p), 64'(rdata1[p]), 64'd0);
            check($sformatf("async reset rready[%0d]", p), 64'(rready1[p]), 64'd0);
        end
        check("async reset err dut0", 64'(err0), 64'd0);
        check("async reset err dut1", 64'(err1), 64'd0);
        do_reset();

        // Randomized run against the model.
        for (int k = 0; k < 400; k++) begin
            random_inputs();
            sample_checks();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prf_multiport.md
# prf_multiport

Parametrised physical register file with a per-register ready scoreboard, a configurable number of write, read and allocate ports, an optional hard-wired zero register, and a selectable combinational or registered read path. It sits between rename/dispatch (allocate, ready query) and the execute/writeback and commit stages (write, operand read). It is the generalised successor of the fixed 2-write/6-read register file.

## Interface
Parameters:
- XLEN, 32, data width
- PREGS, 64, physical entries (power of two, ≥ 4); TW = $clog2(PREGS)
- NWR, 2, write ports (1..4)
- NRD, 6, read ports (1..8)
- NALLOC, 2, allocate ports (1..4)
- RESET_VAL, 0, data value loaded into every entry on reset
- ZERO_PREG, 1, 1 = entry 0 always reads 0 and ready, writes/allocs to it ignored
- REG_READ, 0, 0 = combinational read, 1 = one-cycle registered read

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wen  in  NWR  write enables
- wtag  in  NWR×TW  write tags
- wdata  in  NWR×XLEN  write data
- alloc_en  in  NALLOC  allocate enables (clear ready bit)
- alloc_tag  in  NALLOC×TW  allocated tags
- flush  in  1  set every ready bit
- rtag  in  NRD×TW  read tags
- rdata  out  NRD×XLEN  read data
- rready  out  NRD  ready bit of the read tag
- err_collide  out  1  sticky: two enabled write ports hit the same tag in one cycle

## Operation
- Storage: PREGS×XLEN data flops plus PREGS ready flops.
- Reset: all data entries = RESET_VAL, all ready = 1, err_collide = 0. With REG_READ=1, rdata = 0 and rready = 0. With REG_READ=0, outputs follow the array.
- Write: on each posedge, for every enabled port, entry[wtag] <= wdata and ready[wtag] <= 1.
  - Same tag on several enabled ports: the lowest port index wins.
  - err_collide is set and stays set until reset.
- Allocate: ready[alloc_tag] <= 0 at the posedge.
  - Alloc and write to the same tag in the same cycle: data is written and ready ends at 0 (alloc wins).
  - Duplicate alloc tags are harmless.
- Flush: all ready <= 1 and overrides alloc in that cycle. Writes still update data. Allocs in a flush cycle are discarded.
- ZERO_PREG=1: tag 0 reads rdata = 0 and rready = 1 always. Writes, allocs and collisions on tag 0 are ignored (no err_collide).
- Read, per port, priority order:
  1. zero-reg rule
  2. lowest-index enabled write port with matching tag: data = wdata, ready = 1 (bypass)
  3. stored entry and ready bit
  - Same-cycle allocs are not bypassed into rready.
- Tags are always in range, so no bounds checking is needed.

## Timing
- REG_READ=0: rdata and rready are combinational from rtag, wen, wtag and wdata in the same cycle. Zero latency.
- REG_READ=1: the read result is computed as in REG_READ=0 from the cycle-N inputs (including the cycle-N write bypass), captured at the posedge ending cycle N, and presented in cycle N+1.
- Write and alloc effects are visible in the stored array from cycle N+1.
- Reset asserted mid-operation: the array, ready bits, err_collide and registered outputs return to their reset values immediately (asynchronous). Writes in that cycle are lost.

## Test plan
- Reset with RESET_VAL=4, then read tags 1..5 on ports 0..4 -> rdata = 4, rready = 1; err_collide = 0.
- Cycle 1: alloc tag 9 -> cycle 2 read 9 gives rready = 0. Cycle 3: wen[1], wtag 9, wdata 0xABCD -> same-cycle read gives 0xABCD with rready = 1; cycle 4 stored value is 0xABCD with rready = 1.
- wen[0] and wen[1] both target tag 12 with data 0x11 and 0x22 -> same-cycle read = 0x11; next cycle stored = 0x11; err_collide = 1 and stays 1 until reset.
- Alloc tags 5 and 6, then flush with alloc of 7 in the same cycle -> next cycle rready = 1 for 5, 6 and 7. Alloc and write tag 8 together -> data stored, rready = 0.
- ZERO_PREG=1: write 0xFFFF to tag 0 and alloc tag 0 -> read tag 0 gives 0 with rready = 1; err_collide stays 0.
- REG_READ=1: rtag = 3 while wen[0] writes 0x55 to tag 3 -> rdata = 0x55 with rready = 1 in the next cycle, not in the current one. Reset asserted mid-burst -> rdata = 0 and rready = 0 immediately.
